// File: rtl/wb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : wb_pkg
// Brief    : Shared types and SoC memory-map constants for the Wishbone fabric.
// Revision : 1.0 - initial release
// ============================================================================
package wb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        ERR  = 2'd2
    } wb_state_e;

    localparam int WB_AW = 32;
    localparam int WB_DW = 32;

    // Slave i claims an address when (adr & mask) == base.
    localparam logic [31:0] c_bram_base  = 32'h0000_0000;
    localparam logic [31:0] c_bram_mask  = 32'hF000_0000;
    localparam logic [31:0] c_ddr_base   = 32'h4000_0000;
    localparam logic [31:0] c_ddr_mask   = 32'hC000_0000;
    localparam logic [31:0] c_uart_base  = 32'hF000_0000;
    localparam logic [31:0] c_uart_mask  = 32'hFFFF_0000;
    localparam logic [31:0] c_timer_base = 32'hF001_0000;
    localparam logic [31:0] c_timer_mask = 32'hFFFF_0000;

    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/wb_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : wb_rr_arbiter
// Brief    : Combinational round-robin picker; first requester after last_i.
// Revision : 1.0 - initial release
// ============================================================================
module wb_rr_arbiter #(
    parameter int NM = 2,
    parameter int LW = 1
) (
    input  logic [NM-1:0] req_i,
    input  logic [LW-1:0] last_i,
    output logic [NM-1:0] gnt_o
);

    int w_best_d;

    // Distance 0 is the master right after last_i; the owner itself is farthest.
    always_comb begin
        gnt_o    = '0;
        w_best_d = NM;
        for (int j = 0; j < NM; j++) begin
            if (req_i[j] && (((j + NM - 1 - int'(last_i)) % NM) < w_best_d)) begin
                w_best_d = (j + NM - 1 - int'(last_i)) % NM;
                gnt_o    = '0;
                gnt_o[j] = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/wb_arb_decoder.sv
`default_nettype none
// ============================================================================
// Module   : wb_arb_decoder
// Brief    : Shared-bus Wishbone interconnect: round-robin arbiter, base/mask
//            address decoder, unmapped-access error and bus-timeout watchdog.
// Revision : 1.0 - initial release
// ============================================================================
module wb_arb_decoder
    import wb_pkg::*;
#(
    parameter int               NM       = 2,
    parameter int               NS       = 4,
    parameter int               AW       = WB_AW,
    parameter int               DW       = WB_DW,
    parameter logic [NS*AW-1:0] SLV_BASE = '0,
    parameter logic [NS*AW-1:0] SLV_MASK = '0,
    parameter int               TIMEOUT  = 255
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [NM-1:0]        m_cyc_i,
    input  logic [NM-1:0]        m_stb_i,
    input  logic [NM-1:0]        m_we_i,
    input  logic [NM*AW-1:0]     m_adr_i,
    input  logic [NM*DW-1:0]     m_dat_i,
    input  logic [NM*DW/8-1:0]   m_sel_i,
    output logic [DW-1:0]        m_dat_o,
    output logic [NM-1:0]        m_ack_o,
    output logic [NM-1:0]        m_err_o,
    output logic [NM-1:0]        m_rty_o,
    output logic [NS-1:0]        s_cyc_o,
    output logic [NS-1:0]        s_stb_o,
    output logic                 s_we_o,
    output logic [AW-1:0]        s_adr_o,
    output logic [DW-1:0]        s_dat_o,
    output logic [DW/8-1:0]      s_sel_o,
    input  logic [NS*DW-1:0]     s_dat_i,
    input  logic [NS-1:0]        s_ack_i,
    input  logic [NS-1:0]        s_err_i,
    input  logic [NS-1:0]        s_rty_i,
    output logic [NM-1:0]        gnt_o
);

    localparam int SW = DW / 8;
    localparam int LW = clog2_min1(NM);
    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    wb_state_e     state_q, state_d;
    logic [NM-1:0] gnt_q, gnt_d;
    logic [LW-1:0] last_q, last_d;
    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;

    logic [NM-1:0] w_arb_gnt;
    logic [LW-1:0] w_gnt_idx;
    logic          w_gnt_valid;
    logic          w_cyc;
    logic          w_stb;
    logic [NS-1:0] w_hit;
    logic          w_hit_any;
    logic          w_s_ack;
    logic          w_s_err;
    logic          w_s_rty;
    logic          w_resp;
    logic [DW-1:0] w_rdat;

    wb_rr_arbiter #(
        .NM (NM),
        .LW (LW)
    ) u_arb (
        .req_i  (m_cyc_i),
        .last_i (last_q),
        .gnt_o  (w_arb_gnt)
    );

    assign w_gnt_valid = |gnt_q;
    assign gnt_o       = gnt_q;

    always_comb begin : master_mux
        w_gnt_idx = '0;
        w_cyc     = 1'b0;
        w_stb     = 1'b0;
        s_we_o    = 1'b0;
        s_adr_o   = '0;
        s_dat_o   = '0;
        s_sel_o   = '0;
        for (int i = 0; i < NM; i++) begin
            if (gnt_q[i]) begin
                w_gnt_idx = LW'(i);
                w_cyc     = m_cyc_i[i];
                w_stb     = m_stb_i[i];
                s_we_o    = m_we_i[i];
                s_adr_o   = m_adr_i[i*AW +: AW];
                s_dat_o   = m_dat_i[i*DW +: DW];
                s_sel_o   = m_sel_i[i*SW +: SW];
            end
        end
    end

    // Scan downwards so the lowest-index matching window wins on overlap.
    always_comb begin : addr_decode
        w_hit = '0;
        for (int k = NS - 1; k >= 0; k--) begin
            if ((s_adr_o & SLV_MASK[k*AW +: AW]) == SLV_BASE[k*AW +: AW]) begin
                w_hit    = '0;
                w_hit[k] = 1'b1;
            end
        end
        w_hit_any = |w_hit;
    end

    always_comb begin : resp_mux
        w_s_ack = 1'b0;
        w_s_err = 1'b0;
        w_s_rty = 1'b0;
        w_rdat  = '0;
        for (int k = 0; k < NS; k++) begin
            if (w_hit[k]) begin
                w_s_ack = s_ack_i[k];
                w_s_err = s_err_i[k];
                w_s_rty = s_rty_i[k];
                w_rdat  = s_dat_i[k*DW +: DW];
            end
        end
        w_resp = w_s_ack | w_s_err | w_s_rty;
    end

    assign s_cyc_o = {NS{w_gnt_valid & w_cyc}} & w_hit;
    assign s_stb_o = {NS{w_gnt_valid & w_stb & (state_q == BUSY)}} & w_hit;
    assign m_ack_o = gnt_q & {NM{w_s_ack}};
    assign m_rty_o = gnt_q & {NM{w_s_rty}};
    assign m_err_o = gnt_q & {NM{w_s_err | (state_q == ERR)}};
    assign m_dat_o = w_gnt_valid ? w_rdat : '0;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            last_q    <= LW'(NM - 1);
            tmo_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            last_q    <= last_d;
            tmo_cnt_q <= tmo_cnt_d;
        end
    end

    // The watchdog only counts while a strobe sits unanswered; anything else clears it.
    always_comb begin : fsm_next
        state_d   = state_q;
        gnt_d     = gnt_q;
        last_d    = last_q;
        tmo_cnt_d = '0;
        case (state_q)
            IDLE: begin
                if (|m_cyc_i) begin
                    gnt_d   = w_arb_gnt;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (!w_cyc) begin
                    gnt_d   = '0;
                    last_d  = w_gnt_idx;
                    state_d = IDLE;
                end else if (w_stb && !w_hit_any) begin
                    state_d = ERR;
                end else if (w_stb && !w_resp && (TIMEOUT != 0)) begin
                    if (tmo_cnt_q == TW'(TIMEOUT - 1)) begin
                        state_d = ERR;
                    end else if (tmo_cnt_q != {TW{1'b1}}) begin
                        tmo_cnt_d = tmo_cnt_q + TW'(1);
                    end else begin
                        tmo_cnt_d = tmo_cnt_q;
                    end
                end
            end
            ERR: begin
                state_d = BUSY;
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_wb_arb_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_arb_decoder
// Brief    : Randomised bench for wb_arb_decoder against a transaction model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_arb_decoder;
    import wb_pkg::*;

    localparam int NM      = 2;
    localparam int NS      = 4;
    localparam int AW      = 32;
    localparam int DW      = 32;
    localparam int TIMEOUT = 8;
    localparam int NEVER   = 1000;

    // Slave 3 is a catch-all for 0xFxxx_xxxx overlapping the UART window.
    localparam logic [31:0] C_BASE [NS] = '{c_bram_base, c_ddr_base, c_uart_base, 32'hF000_0000};
    localparam logic [31:0] C_MASK [NS] = '{c_bram_mask, c_ddr_mask, c_uart_mask, 32'hF000_0000};
    localparam logic [NS*AW-1:0] SLV_BASE = {C_BASE[3], C_BASE[2], C_BASE[1], C_BASE[0]};
    localparam logic [NS*AW-1:0] SLV_MASK = {C_MASK[3], C_MASK[2], C_MASK[1], C_MASK[0]};

    logic               clk = 1'b0;
    logic               rst_i;
    logic [NM-1:0]      m_cyc, m_stb, m_we;
    logic [NM*AW-1:0]   m_adr;
    logic [NM*DW-1:0]   m_dat;
    logic [NM*DW/8-1:0] m_sel;
    logic [DW-1:0]      m_dat_o;
    logic [NM-1:0]      m_ack_o, m_err_o, m_rty_o, gnt_o;
    logic [NS-1:0]      s_cyc_o, s_stb_o;
    logic               s_we_o;
    logic [AW-1:0]      s_adr_o;
    logic [DW-1:0]      s_dat_o;
    logic [DW/8-1:0]    s_sel_o;
    logic [NS*DW-1:0]   s_dat_i;
    logic [NS-1:0]      s_ack_i, s_err_i, s_rty_i;

    int n_chk = 0;
    int n_err = 0;

    int          lat  [NS];
    int          kind [NS];
    int          scnt [NS];
    bit          pend [NM];
    logic [31:0] madr [NM];
    logic [31:0] mdat [NM];
    logic [3:0]  msel [NM];
    logic        mwe  [NM];
    int          last;

    wb_arb_decoder #(
        .NM       (NM),
        .NS       (NS),
        .AW       (AW),
        .DW       (DW),
        .SLV_BASE (SLV_BASE),
        .SLV_MASK (SLV_MASK),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk_i   (clk),
        .rst_i   (rst_i),
        .m_cyc_i (m_cyc),
        .m_stb_i (m_stb),
        .m_we_i  (m_we),
        .m_adr_i (m_adr),
        .m_dat_i (m_dat),
        .m_sel_i (m_sel),
        .m_dat_o (m_dat_o),
        .m_ack_o (m_ack_o),
        .m_err_o (m_err_o),
        .m_rty_o (m_rty_o),
        .s_cyc_o (s_cyc_o),
        .s_stb_o (s_stb_o),
        .s_we_o  (s_we_o),
        .s_adr_o (s_adr_o),
        .s_dat_o (s_dat_o),
        .s_sel_o (s_sel_o),
        .s_dat_i (s_dat_i),
        .s_ack_i (s_ack_i),
        .s_err_i (s_err_i),
        .s_rty_i (s_rty_i),
        .gnt_o   (gnt_o)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rdata(input int k, input logic [31:0] a);
        logic [3:0] kk;
        kk = k[3:0];
        return {kk, a[27:0]} ^ 32'h0F0F_A5A5;
    endfunction

    // Slaves answer after lat[k] cycles of seeing a strobe, with kind 0=ack 1=err 2=rty.
    always_comb begin
        s_ack_i = '0;
        s_err_i = '0;
        s_rty_i = '0;
        s_dat_i = '0;
        for (int k = 0; k < NS; k++) begin
            s_dat_i[k*DW +: DW] = rdata(k, s_adr_o);
            if (s_cyc_o[k] && s_stb_o[k] && (scnt[k] == lat[k])) begin
                if (kind[k] == 0)      s_ack_i[k] = 1'b1;
                else if (kind[k] == 1) s_err_i[k] = 1'b1;
                else                   s_rty_i[k] = 1'b1;
            end
        end
    end

    always @(posedge clk or posedge rst_i) begin
        for (int k = 0; k < NS; k++) begin
            if (rst_i)
                scnt[k] <= 0;
            else if (s_stb_o[k] && !(s_ack_i[k] || s_err_i[k] || s_rty_i[k]))
                scnt[k] <= scnt[k] + 1;
            else
                scnt[k] <= 0;
        end
    end

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int decode(input logic [31:0] a);
        for (int k = 0; k < NS; k++)
            if ((a & C_MASK[k]) == C_BASE[k]) return k;
        return -1;
    endfunction

    function automatic int next_winner();
        for (int i = 1; i <= NM; i++)
            if (pend[(last + i) % NM]) return (last + i) % NM;
        return -1;
    endfunction

    task automatic set_addr(input int m);
        logic [31:0] a;
        a = $urandom;
        case ($urandom_range(0, 4))
            0:       a = a & 32'h0FFF_FFFC;
            1:       a = 32'h4000_0000 | (a & 32'h3FFF_FFFC);
            2:       a = 32'hF000_0000 | (a & 32'h0000_FFFC);
            3:       a = 32'hF0F0_0000 | (a & 32'h000F_FFFC);
            default: a = 32'h8000_0000 | (a & 32'h3FFF_FFFC);
        endcase
        madr[m] = a;
        mdat[m] = $urandom;
        msel[m] = 4'($urandom_range(0, 15));
        mwe[m]  = 1'($urandom_range(0, 1));
        m_adr[m*AW +: AW]  = madr[m];
        m_dat[m*DW +: DW]  = mdat[m];
        m_sel[m*4 +: 4]    = msel[m];
        m_we[m]            = mwe[m];
    endtask

    task automatic pick_req(input int m);
        set_addr(m);
        m_cyc[m] = 1'b1;
        m_stb[m] = 1'b1;
        pend[m]  = 1'b1;
    endtask

    task automatic cfg_slaves();
        int p;
        for (int k = 0; k < NS; k++) begin
            p       = $urandom_range(0, 5);
            lat[k]  = (p == 5) ? NEVER : ((p == 4) ? TIMEOUT - 1 : p);
            p       = $urandom_range(0, 5);
            kind[k] = (p < 4) ? 0 : ((p == 4) ? 1 : 2);
        end
    endtask

    // One ownership period: grant, 1..3 transfers under a held cyc, release.
    task automatic run_grant();
        int            w, nx, es, ec, ek, c;
        logic [NM-1:0] oh;
        logic [5:0]    er;
        for (int m = 0; m < NM; m++)
            if (!pend[m] && ($urandom_range(0, 1) == 1)) pick_req(m);
        if (next_winner() < 0) pick_req($urandom_range(0, NM - 1));
        w  = next_winner();
        oh = NM'(1) << w;
        nx = $urandom_range(1, 3);
        cfg_slaves();
        @(posedge clk); #1;
        for (int t = 0; t < nx; t++) begin
            if (t > 0) begin
                set_addr(w);
                cfg_slaves();
                m_stb[w] = 1'b1;
                #1;
            end
            es = decode(madr[w]);
            check_val("gnt", gnt_o, oh);
            check_val("s_stb", s_stb_o, (es < 0) ? 0 : (1 << es));
            check_val("s_cyc", s_cyc_o, (es < 0) ? 0 : (1 << es));
            check_val("s_adr", s_adr_o, madr[w]);
            check_val("s_wr", {s_we_o, s_sel_o, s_dat_o}, {mwe[w], msel[w], mdat[w]});
            if (es < 0)                 begin ec = 2;           ek = 1;        end
            else if (lat[es] < TIMEOUT) begin ec = lat[es] + 1; ek = kind[es]; end
            else                        begin ec = TIMEOUT + 1; ek = 1;        end
            er = (ek == 0) ? {oh, 2'b00, 2'b00} : ((ek == 1) ? {2'b00, oh, 2'b00} : {2'b00, 2'b00, oh});
            c = 1;
            while (((m_ack_o | m_err_o | m_rty_o) == '0) && (c < 40)) begin
                @(posedge clk); #1;
                c++;
            end
            check_val("resp_cycle", c, ec);
            check_val("resp_vec", {m_ack_o, m_err_o, m_rty_o}, er);
            if ((es >= 0) && (ek == 0))
                check_val("rdata", m_dat_o, rdata(es, madr[w]));
            m_stb[w] = 1'b0;
            @(posedge clk); #1;
            check_val("resp_clear", {m_ack_o, m_err_o, m_rty_o}, 0);
        end
        m_cyc[w] = 1'b0;
        pend[w]  = 1'b0;
        @(posedge clk); #1;
        check_val("dead_cycle", gnt_o, 0);
        last = w;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int w;
        rst_i = 1'b1;
        m_cyc = '0; m_stb = '0; m_we = '0; m_adr = '0; m_dat = '0; m_sel = '0;
        for (int k = 0; k < NS; k++) begin lat[k] = 0; kind[k] = 0; end
        for (int m = 0; m < NM; m++) pend[m] = 1'b0;
        last = NM - 1;
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_gnt", gnt_o, 0);
        check_val("rst_slave", {s_cyc_o, s_stb_o}, 0);
        check_val("rst_master", {m_ack_o, m_err_o, m_rty_o}, 0);
        check_val("rst_bus", {s_we_o, s_sel_o, s_adr_o}, 0);
        check_val("rst_data", {s_dat_o, m_dat_o}, 0);
        rst_i = 1'b0;

        pick_req(0);
        pick_req(1);
        repeat (60) run_grant();

        // Reset in the middle of a transfer that is still waiting for its slave.
        if (next_winner() < 0) pick_req(0);
        w = next_winner();
        madr[w] = 32'h0000_0010;
        m_adr[w*AW +: AW] = madr[w];
        for (int k = 0; k < NS; k++) lat[k] = NEVER;
        @(posedge clk); #1;
        check_val("pre_rst_gnt", gnt_o, 1 << w);
        check_val("pre_rst_stb", s_stb_o, 4'b0001);
        #2;
        rst_i = 1'b1;
        #1;
        check_val("async_rst_slave", {s_cyc_o, s_stb_o}, 0);
        check_val("async_rst_gnt", gnt_o, 0);
        m_cyc = '0;
        m_stb = '0;
        for (int m = 0; m < NM; m++) pend[m] = 1'b0;
        @(posedge clk); #1;
        rst_i = 1'b0;
        last  = NM - 1;
        @(posedge clk); #1;
        check_val("post_rst_idle", gnt_o, 0);
        pick_req(0);
        pick_req(1);
        run_grant();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule
`default_nettype wire
